pll_reset_seq: RTL
==================

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive cycles of synchronized lock required before reset release; minimum 2.
REQ-002 SHALL have parameter STAGE_GAP_CYCLES, default 16: cycles between successive reset-domain releases; minimum 1.
REQ-003 SHALL have parameter UNLOCK_TIMEOUT_CYCLES, default 65536: cycles spent waiting for lock before the PLL is re-reset.
REQ-004 SHALL have parameter PLL_RST_PULSE, default 8: width in cycles of the PLL reset pulse; minimum 1.
REQ-005 SHALL have port clk, input, 1: the single clock; every flop in the block is clocked by it.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port pll_lock_i, input, 1: PLL lock flag, asynchronous to clk.
REQ-008 SHALL have port pll_rst_o, output, 1: reset request to the PLL, active-high.
REQ-009 SHALL have port rst_core_o, output, 1: core-logic reset, active-high, released first.
REQ-010 SHALL have port rst_video_o, output, 1: video reset, active-high, released second.
REQ-011 SHALL have port rst_audio_o, output, 1: audio reset, active-high, released last.
REQ-012 SHALL have port ready_o, output, 1: high only in the RUN state.
REQ-013 SHALL have port lock_loss_cnt_o, output, 8: count of lock losses after release, saturating.

Function
REQ-014 SHALL pass pll_lock_i through a 2-flop synchronizer to give lock_s; lock_s follows pll_lock_i with a latency of 2 clock edges.
REQ-015 SHALL drive every output from a flop; no combinational path from any input to any output.
REQ-016 SHALL implement the states WAIT_LOCK, STABLE, RELEASE, RUN and PLL_RST, with one shared cycle counter of at least 17 bits.
REQ-017 WAIT_LOCK: on lock_s=1, go to STABLE with the counter set to 1; otherwise increment the counter, and when it reaches UNLOCK_TIMEOUT_CYCLES-1 go to PLL_RST.
REQ-018 STABLE: on lock_s=0, go to WAIT_LOCK with the counter cleared; otherwise increment, and when the counter reaches LOCK_STABLE_CYCLES go to RELEASE with the counter cleared.
REQ-019 PLL_RST: drive pll_rst_o=1 for exactly PLL_RST_PULSE cycles, then go to WAIT_LOCK with the counter cleared; lock_s is ignored while in PLL_RST.
REQ-020 In all states other than PLL_RST, pll_rst_o SHALL be 0.
REQ-021 On entry to RELEASE, rst_core_o SHALL deassert (its registered value falls on the transition edge).
REQ-022 In RELEASE, rst_video_o SHALL deassert STAGE_GAP_CYCLES edges after rst_core_o.
REQ-023 rst_audio_o SHALL deassert, and ready_o assert, 2*STAGE_GAP_CYCLES edges after rst_core_o, on the same edge as the state enters RUN.
REQ-024 Timing with pll_lock_i held high: rst_core_o falls exactly LOCK_STABLE_CYCLES+2 edges after the first edge that samples pll_lock_i=1.
REQ-025 In RELEASE or RUN, lock_s=0 SHALL cause all of the following on the next edge, then go to WAIT_LOCK with the counter cleared:
  - rst_core_o, rst_video_o and rst_audio_o reasserted;
  - ready_o cleared;
  - lock_loss_cnt_o incremented.
REQ-026 lock_loss_cnt_o SHALL saturate at 255 and SHALL never wrap.
REQ-027 Lock loss in WAIT_LOCK or STABLE SHALL NOT increment lock_loss_cnt_o.
REQ-028 Once asserted, a reset output SHALL stay asserted until its release point in a later RELEASE pass.
REQ-029 Reset outputs SHALL release only in the order core, then video, then audio; no two in the same cycle.
REQ-030 A glitch of lock_s=0 shorter than one cycle after synchronization SHALL restart the STABLE count; there is no hysteresis beyond the synchronizer.

Reset
REQ-031 With rst=1 on an edge, the following SHALL apply on that edge, regardless of the current state (including mid-RELEASE or mid-PLL_RST):
  - state = WAIT_LOCK;
  - counter = 0;
  - synchronizer flops = 0;
  - pll_rst_o = 0;
  - rst_core_o = rst_video_o = rst_audio_o = 1;
  - ready_o = 0;
  - lock_loss_cnt_o = 0.
REQ-032 The first state evaluation after rst deasserts SHALL use the cleared synchronizer, so release can never occur earlier than REQ-024 allows.

Verification
Bench parameters: LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4, UNLOCK_TIMEOUT_CYCLES=32, PLL_RST_PULSE=3.
REQ-033 Clean lock: after reset, pll_lock_i=1 sampled first at edge 0 -> rst_core_o falls at edge 10, rst_video_o at edge 14, rst_audio_o and ready_o at edge 18; pll_rst_o stays 0.
REQ-034 Glitch during STABLE: pll_lock_i low for 2 cycles while in STABLE -> the count restarts, release is delayed by the full LOCK_STABLE_CYCLES from the recovery, and lock_loss_cnt_o stays 0.
REQ-035 Lock loss in RUN: pll_lock_i drops -> all three resets high and ready_o low 3 edges later, lock_loss_cnt_o=1, then a normal re-release when lock returns.
REQ-036 Timeout: pll_lock_i held 0 -> pll_rst_o high for exactly 3 cycles starting 32 cycles after reset, repeating every 35 cycles; the resets stay asserted throughout.
REQ-037 Saturation: 300 lock-loss events in RUN -> lock_loss_cnt_o=255 and held there.
REQ-038 Reset mid-RELEASE: rst=1 one cycle after rst_core_o falls -> all resets=1, ready_o=0 and lock_loss_cnt_o=0 on that edge; the next release again obeys REQ-024.

Source files
------------

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_seq
// Description : Waits for a stable PLL lock, then releases the core, video and
//               audio reset domains in order; re-resets the PLL on lock timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq #(
    parameter int LOCK_STABLE_CYCLES    = 1024,
    parameter int STAGE_GAP_CYCLES      = 16,
    parameter int UNLOCK_TIMEOUT_CYCLES = 65536,
    parameter int PLL_RST_PULSE         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock_i,
    output logic       pll_rst_o,
    output logic       rst_core_o,
    output logic       rst_video_o,
    output logic       rst_audio_o,
    output logic       ready_o,
    output logic [7:0] lock_loss_cnt_o
);

    localparam int c_MAX_A   = (LOCK_STABLE_CYCLES > UNLOCK_TIMEOUT_CYCLES) ?
                               LOCK_STABLE_CYCLES : UNLOCK_TIMEOUT_CYCLES;
    localparam int c_MAX_B   = (PLL_RST_PULSE > 2 * STAGE_GAP_CYCLES) ?
                               PLL_RST_PULSE : 2 * STAGE_GAP_CYCLES;
    localparam int c_MAX     = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W   = ($clog2(c_MAX + 1) > 17) ? $clog2(c_MAX + 1) : 17;

    localparam logic [c_CNT_W-1:0] c_ONE          = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_STABLE_DONE  = c_CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(UNLOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST   = c_CNT_W'(PLL_RST_PULSE - 1);
    localparam logic [c_CNT_W-1:0] c_VIDEO_REL    = c_CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_AUDIO_REL    = c_CNT_W'(2 * STAGE_GAP_CYCLES - 1);

    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] c_ST_STABLE    = 3'd1;
    localparam logic [2:0] c_ST_RELEASE   = 3'd2;
    localparam logic [2:0] c_ST_RUN       = 3'd3;
    localparam logic [2:0] c_ST_PLL_RST   = 3'd4;

    logic               r_sync_meta;
    logic               r_lock_s;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_pll_rst;
    logic               r_rst_core;
    logic               r_rst_video;
    logic               r_rst_audio;
    logic               r_ready;
    logic [7:0]         r_loss_cnt;
    logic [7:0]         w_loss_cnt_inc;

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_sync_meta <= pll_lock_i;
            r_lock_s    <= r_sync_meta;
        end
    end

    assign w_loss_cnt_inc = (r_loss_cnt == 8'hFF) ? r_loss_cnt : r_loss_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b0;
            r_rst_core  <= 1'b1;
            r_rst_video <= 1'b1;
            r_rst_audio <= 1'b1;
            r_ready     <= 1'b0;
            r_loss_cnt  <= 8'd0;
        end else begin
            case (r_state)
                c_ST_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        r_state <= c_ST_STABLE;
                        r_cnt   <= c_ONE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_state   <= c_ST_PLL_RST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end

                c_ST_STABLE: begin
                    if (!r_lock_s) begin
                        r_state <= c_ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_STABLE_DONE) begin
                        r_state    <= c_ST_RELEASE;
                        r_cnt      <= '0;
                        r_rst_core <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end

                c_ST_RELEASE: begin
                    if (!r_lock_s) begin
                        r_state     <= c_ST_WAIT_LOCK;
                        r_cnt       <= '0;
                        r_rst_core  <= 1'b1;
                        r_rst_video <= 1'b1;
                        r_rst_audio <= 1'b1;
                        r_ready     <= 1'b0;
                        r_loss_cnt  <= w_loss_cnt_inc;
                    end else begin
                        if (r_cnt == c_VIDEO_REL) begin
                            r_rst_video <= 1'b0;
                        end
                        // Video release point is always strictly earlier, so
                        // the domains never come out of reset on the same edge.
                        if (r_cnt == c_AUDIO_REL) begin
                            r_state     <= c_ST_RUN;
                            r_cnt       <= '0;
                            r_rst_audio <= 1'b0;
                            r_ready     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end

                c_ST_RUN: begin
                    if (!r_lock_s) begin
                        r_state     <= c_ST_WAIT_LOCK;
                        r_cnt       <= '0;
                        r_rst_core  <= 1'b1;
                        r_rst_video <= 1'b1;
                        r_rst_audio <= 1'b1;
                        r_ready     <= 1'b0;
                        r_loss_cnt  <= w_loss_cnt_inc;
                    end
                end

                c_ST_PLL_RST: begin
                    // Lock is deliberately ignored while the PLL is held in reset.
                    if (r_cnt == c_PULSE_LAST) begin
                        r_state   <= c_ST_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end

                default: begin
                    r_state     <= c_ST_WAIT_LOCK;
                    r_cnt       <= '0;
                    r_pll_rst   <= 1'b0;
                    r_rst_core  <= 1'b1;
                    r_rst_video <= 1'b1;
                    r_rst_audio <= 1'b1;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst_o       = r_pll_rst;
    assign rst_core_o      = r_rst_core;
    assign rst_video_o     = r_rst_video;
    assign rst_audio_o     = r_rst_audio;
    assign ready_o         = r_ready;
    assign lock_loss_cnt_o = r_loss_cnt;

endmodule
`default_nettype wire
